// File: rtl/mdu_sequencer_if.sv
// Bundle of the request/result handshake and the shared-ALU operand lines
// between the Execute stage and the multiply/divide sequencer.
interface mdu_sequencer_if;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_carry;

    modport master (
        output start, flush, op, rs1, rs2, alu_result, alu_carry,
        input  busy, done, result, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  start, flush, op, rs1, rs2, alu_result, alu_carry,
        output busy, done, result, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and
// restoring divide, borrowing the Execute-stage ALU for every add/subtract.
module mdu_sequencer (
    input  logic            clk,
    input  logic            rst_n,
    mdu_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] result_q, result_d;
    logic        sign_q, sign_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        is_div;
    logic        rs1_signed, rs2_signed;
    logic        rs1_neg, rs2_neg;
    logic [31:0] rs1_mag, rs2_mag;
    logic        div_zero;
    logic [31:0] div_shift;
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;

    // Operand interpretation derived from the latched funct3
    always_comb begin
        is_div     = op_q[2];
        rs1_signed = is_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
        rs2_signed = is_div ? ~op_q[0] : ~op_q[1];
        rs1_neg    = rs1_signed & rs1_q[31];
        rs2_neg    = rs2_signed & rs2_q[31];
        rs1_mag    = rs1_neg ? (~rs1_q + 32'd1) : rs1_q;
        rs2_mag    = rs2_neg ? (~rs2_q + 32'd1) : rs2_q;
        div_zero   = is_div && (rs2_q == 32'd0);
        div_shift  = {hi_q[30:0], lo_q[31]};
        prod       = {hi_q, lo_q};
        prod_fix   = sign_q ? (~prod + 64'd1) : prod;
        quo_fix    = sign_q ? (~lo_q + 32'd1) : lo_q;
        rem_fix    = sign_q ? (~hi_q + 32'd1) : hi_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_d    = mag_q;
        result_d = result_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_ctrl = 4'b0000;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    rs1_d   = bus.rs1;
                    rs2_d   = bus.rs2;
                    state_d = PREP;
                end
            end
            PREP: begin
                hi_d   = 32'd0;
                cnt_d  = 6'd0;
                lo_d   = is_div ? rs1_mag : rs2_mag;
                mag_d  = is_div ? rs2_mag : rs1_mag;
                // Remainder takes the dividend's sign; everything else the XOR
                sign_d = (is_div && op_q[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
                if (div_zero) begin
                    result_d = op_q[1] ? rs1_q : 32'hFFFF_FFFF;
                    state_d  = DONE;
                end else begin
                    state_d  = ITER;
                end
            end
            ITER: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div) begin
                    alu_a    = div_shift;
                    alu_b    = mag_q;
                    alu_ctrl = 4'b1000;
                    if (hi_q[31] || !bus.alu_carry) begin
                        hi_d = bus.alu_result;
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = div_shift;
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else begin
                    alu_a        = hi_q;
                    alu_b        = lo_q[0] ? mag_q : 32'd0;
                    alu_ctrl     = 4'b0000;
                    {hi_d, lo_d} = {bus.alu_carry, bus.alu_result, lo_q[31:1]};
                end
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div) begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                end else begin
                    result_d = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort discards the operation in flight, including a pending result
        if (bus.flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            mag_q    <= 32'd0;
            result_q <= 32'd0;
            sign_q   <= 1'b0;
            cnt_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.alu_a    = alu_a;
    assign bus.alu_b    = alu_b;
    assign bus.alu_ctrl = alu_ctrl;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: a behavioural 32-bit ALU closes the loop
// and each RV32M operation is checked for result value and completion cycle.
module tb_mdu_sequencer;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [32:0] alu_sum;
    logic [32:0] alu_diff;

    mdu_sequencer_if mif ();

    mdu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Execute-stage ALU: carry is carry-out on add and borrow on subtract
    always_comb begin
        alu_sum  = {1'b0, mif.alu_a} + {1'b0, mif.alu_b};
        alu_diff = {1'b0, mif.alu_a} - {1'b0, mif.alu_b};
        if (mif.alu_ctrl == 4'b1000) begin
            mif.alu_result = alu_diff[31:0];
            mif.alu_carry  = alu_diff[32];
        end else begin
            mif.alu_result = alu_sum[31:0];
            mif.alu_carry  = alu_sum[32];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Issues one operation from a post-edge point in IDLE and follows it to done
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expected, input int exp_cycle);
        int          cyc;
        int          done_cyc;
        logic [31:0] res_at_done;
        logic        busy_all;
        mif.start = 1'b1;
        mif.op    = op;
        mif.rs1   = a;
        mif.rs2   = b;
        @(posedge clk); #1;
        mif.start   = 1'b0;
        cyc         = 1;
        done_cyc    = 0;
        res_at_done = 32'd0;
        busy_all    = 1'b1;
        while (cyc <= 60 && done_cyc == 0) begin
            if (!mif.busy) busy_all = 1'b0;
            if (cyc == 2 && exp_cycle == 35)
                checkOutput({tag, " alu_ctrl"}, {28'd0, mif.alu_ctrl}, op[2] ? 32'h8 : 32'h0);
            if (mif.done) begin
                done_cyc    = cyc;
                res_at_done = mif.result;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput({tag, " done_cycle"}, done_cyc, exp_cycle);
        checkOutput({tag, " result"}, res_at_done, expected);
        checkOutput({tag, " busy_held"}, {31'd0, busy_all}, 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, " busy_after"}, {31'd0, mif.busy}, 32'd0);
        checkOutput({tag, " done_after"}, {31'd0, mif.done}, 32'd0);
        checkOutput({tag, " result_held"}, mif.result, expected);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic done_seen;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        mif.start   = 1'b0;
        mif.flush   = 1'b0;
        mif.op      = 3'd0;
        mif.rs1     = 32'd0;
        mif.rs2     = 32'd0;

        #2;
        checkOutput("reset busy", {31'd0, mif.busy}, 32'd0);
        checkOutput("reset done", {31'd0, mif.done}, 32'd0);
        checkOutput("reset result", mif.result, 32'd0);
        checkOutput("reset alu_ctrl", {28'd0, mif.alu_ctrl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("MUL",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        applyStimulus("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        applyStimulus("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);

        // Abort in cycle 10 of a multiply; the previous result must survive
        mif.start = 1'b1;
        mif.op    = 3'b000;
        mif.rs1   = 32'd7;
        mif.rs2   = 32'd3;
        @(posedge clk); #1;
        mif.start = 1'b0;
        done_seen = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (mif.done) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        mif.flush = 1'b1;
        @(posedge clk); #1;
        mif.flush = 1'b0;
        if (mif.done) done_seen = 1'b1;
        checkOutput("flush busy", {31'd0, mif.busy}, 32'd0);
        checkOutput("flush no_done", {31'd0, done_seen}, 32'd0);
        checkOutput("flush result_kept", mif.result, 32'hFFFF_FFFE);

        applyStimulus("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 35);
        applyStimulus("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35);
        applyStimulus("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35);
        applyStimulus("DIVU",   3'b101, 32'd100,        32'd7,         32'd14,        35);
        applyStimulus("REMU",   3'b111, 32'd100,        32'd7,         32'd2,         35);
        applyStimulus("DIVU0",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
        applyStimulus("REM0",   3'b110, 32'd5,          32'd0,         32'd5,         2);
        applyStimulus("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         35);
        applyStimulus("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35);

        // Flush and start together in IDLE: the start is dropped
        mif.start = 1'b1;
        mif.flush = 1'b1;
        mif.op    = 3'b000;
        mif.rs1   = 32'd9;
        mif.rs2   = 32'd9;
        @(posedge clk); #1;
        mif.start = 1'b0;
        mif.flush = 1'b0;
        checkOutput("flush_start busy", {31'd0, mif.busy}, 32'd0);
        @(posedge clk); #1;
        checkOutput("flush_start busy_later", {31'd0, mif.busy}, 32'd0);
        checkOutput("flush_start result", mif.result, 32'h8000_0000);

        // Asynchronous reset in the middle of a divide
        mif.start = 1'b1;
        mif.op    = 3'b101;
        mif.rs1   = 32'h1234_5678;
        mif.rs2   = 32'd3;
        @(posedge clk); #1;
        mif.start = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("pre_reset alu_ctrl", {28'd0, mif.alu_ctrl}, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", {31'd0, mif.busy}, 32'd0);
        checkOutput("midreset done", {31'd0, mif.done}, 32'd0);
        checkOutput("midreset result", mif.result, 32'd0);
        checkOutput("midreset alu_a", mif.alu_a, 32'd0);
        checkOutput("midreset alu_b", mif.alu_b, 32'd0);
        checkOutput("midreset alu_ctrl", {28'd0, mif.alu_ctrl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("MUL3x4", 3'b000, 32'd3, 32'd4, 32'd12, 35);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative RV32M multiply/divide sequencer that time-shares the execute-stage 32-bit ALU for its add/subtract steps. It accepts one operation per start pulse and latches the operands. It runs a 32-step shift-add multiply or a restoring divide, driving the ALU operand and control lines each step. It returns a single 32-bit result with a one-cycle done pulse. It sits beside the ALU in the Execute stage; the pipeline stalls on busy.

## Interface
- XLEN, 32: operand/result width; only 32 supported.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort; highest priority after reset.
- op  input  3  RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1, rs2  input  32  dividend/multiplicand, divisor/multiplier.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  held from DONE until the next accepted start.
- alu_a, alu_b  output  32  ALU operands.
- alu_ctrl  output  4  ALU control; 4'b0000 add, 4'b1000 subtract.
- alu_result  input  32  ALU result.
- alu_carry  input  1  ALU Carry flag.
  - Add: carry-out.
  - Subtract: 1 = borrow (a < b unsigned).

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 latches op, rs1, rs2 and goes to PREP.
  - start is ignored in all other states.
- PREP (1 cycle):
  - Take magnitudes: the internal negator negates an operand if it is signed-interpreted and its bit 31 is set.
  - Signedness: MUL/MULH/DIV/REM both operands signed; MULHSU rs1 only; MULHU/DIVU/REMU neither.
  - Record sign of the final result:
    - MUL*: XOR of the operand signs.
    - DIV: XOR of the operand signs.
    - REM: sign of rs1.
  - Clear the 6-bit step counter; go to ITER.
  - Divide with rs2==0 goes straight to DONE with no ALU use:
    - Quotient result = 0xFFFFFFFF.
    - Remainder result = rs1.
- ITER, multiply (32 steps):
  - Registers: hi=0, lo=|multiplier|.
  - alu_a=hi, alu_b = lo[0] ? |multiplicand| : 0, alu_ctrl=0000.
  - Update {hi,lo} <= {alu_carry, alu_result, lo[31:1]}.
- ITER, divide (32 steps):
  - Registers: rem=0, quo=|dividend|.
  - alu_a={rem[30:0],quo[31]}, alu_b=|divisor|, alu_ctrl=1000.
  - If rem[31]==1 or alu_carry==0: rem<=alu_result, quo<={quo[30:0],1}.
  - Else: rem<=alu_a, quo<={quo[30:0],0}.
- Counter increments every ITER cycle; the 32nd step goes to FIX.
- FIX (1 cycle):
  - Negate the 64-bit product or the quotient/remainder if the recorded sign is 1.
  - Select the output: MUL low 32; MULH/MULHSU/MULHU high 32; DIV/DIVU quotient; REM/REMU remainder.
- DONE (1 cycle): done=1, result registered; then back to IDLE.
- Overflow case DIV 0x80000000/0xFFFFFFFF falls out naturally: quotient 0x80000000, remainder 0.
- Outside ITER: alu_a=0, alu_b=0, alu_ctrl=0000.
- Reset and flush:
  - rst_n low, any time: state IDLE; busy=0, done=0, result=0; alu_a=0, alu_b=0, alu_ctrl=0.
  - flush=1 in any state: next state IDLE, no done pulse, result unchanged.
  - flush and start in the same IDLE cycle: flush wins; start is dropped.

## Timing
- Cycle 0: start sampled at the rising edge. Cycle 1: PREP. Cycles 2–33: ITER. Cycle 34: FIX. Cycle 35: DONE, done=1.
- Divide by zero: cycle 1 PREP, cycle 2 DONE.
- busy rises in cycle 1 and falls in the cycle after DONE.
- A new start is accepted in the first IDLE cycle, giving back-to-back throughput of 36 cycles.
- ALU path is combinational within one ITER cycle: alu_result/alu_carry must settle within the same cycle as alu_a/alu_b/alu_ctrl.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly in cycle 35; busy high in cycles 1–35.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with done in cycle 2. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- flush asserted in cycle 10 -> IDLE next cycle, no done, result keeps the prior value; start in the following cycle completes normally.
- rst_n pulled low mid-ITER -> all outputs 0 immediately; after release a fresh MUL 3×4 -> 12 in cycle 35. Bench uses the real ALU.
